// File: rtl/sobel_edge.sv
// rtl/sobel_edge.sv - streaming 3x3 Sobel edge detector with two line buffers
module sobel_edge #(
    parameter int WIDTH  = 400,
    parameter int HEIGHT = 266,
    parameter int THRESH = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] gray_in,
    input  logic       in_valid,
    input  logic       in_sof,
    output logic [7:0] pixel_out,
    output logic       out_valid,
    output logic       out_sof,
    output logic       out_eol
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [31:0] THRESH_U = 32'(THRESH);

    logic [XW-1:0] x, cur_x;
    logic [YW-1:0] y, cur_y;

    logic [7:0] lb1 [WIDTH];
    logic [7:0] lb2 [WIDTH];
    logic [7:0] win [3][3];

    logic              s0_valid, s0_sof, s0_eol;
    logic signed [10:0] gx_c, gy_c;
    logic signed [10:0] s1_gx, s1_gy;
    logic              s1_valid, s1_sof, s1_eol;
    logic [11:0]       mag;
    logic [7:0]        pix_c;

    function automatic logic signed [10:0] ext(input logic [7:0] p);
        return $signed({3'b000, p});
    endfunction

    function automatic logic [10:0] absv(input logic signed [10:0] v);
        return v[10] ? 11'(-v) : 11'(v);
    endfunction

    // in_sof forces the current pixel to frame origin regardless of counters
    always_comb begin
        cur_x = in_sof ? '0 : x;
        cur_y = in_sof ? '0 : y;
    end

    // raster position counters, wrapping x then y; frozen during gaps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (in_valid) begin
            if (cur_x == XW'(WIDTH - 1)) begin
                x <= '0;
                y <= (cur_y == YW'(HEIGHT - 1)) ? '0 : cur_y + 1'b1;
            end else begin
                x <= cur_x + 1'b1;
                y <= cur_y;
            end
        end
    end

    // line buffers: y-1 row moves into the y-2 buffer, new pixel into y-1
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb2[cur_x] <= lb1[cur_x];
            lb1[cur_x] <= gray_in;
        end
    end

    // 3x3 window shifts left; new right column is {y-2, y-1, current}
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= 8'h00;
        end else if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb2[cur_x];
            win[1][2] <= lb1[cur_x];
            win[2][2] <= gray_in;
        end
    end

    // stage 0 flags: only interior centers (input x>=2, y>=2) produce output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_valid <= 1'b0;
            s0_sof   <= 1'b0;
            s0_eol   <= 1'b0;
        end else begin
            s0_valid <= in_valid && (cur_x >= XW'(2)) && (cur_y >= YW'(2));
            s0_sof   <= in_valid && (cur_x == XW'(2)) && (cur_y == YW'(2));
            s0_eol   <= in_valid && (cur_x == XW'(WIDTH - 1)) && (cur_y >= YW'(2));
        end
    end

    // horizontal and vertical gradients of the current window
    always_comb begin
        gx_c = (ext(win[0][2]) + ext(win[1][2]) + ext(win[1][2]) + ext(win[2][2]))
             - (ext(win[0][0]) + ext(win[1][0]) + ext(win[1][0]) + ext(win[2][0]));
        gy_c = (ext(win[2][0]) + ext(win[2][1]) + ext(win[2][1]) + ext(win[2][2]))
             - (ext(win[0][0]) + ext(win[0][1]) + ext(win[0][1]) + ext(win[0][2]));
    end

    // stage 1: register gradients alongside the qualification flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_gx    <= '0;
            s1_gy    <= '0;
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
        end else begin
            s1_gx    <= gx_c;
            s1_gy    <= gy_c;
            s1_valid <= s0_valid;
            s1_sof   <= s0_sof;
            s1_eol   <= s0_eol;
        end
    end

    // magnitude, then saturate or binarise depending on THRESH
    always_comb begin
        mag = {1'b0, absv(s1_gx)} + {1'b0, absv(s1_gy)};
        if (THRESH == 0)
            pix_c = (mag > 12'd255) ? 8'hFF : mag[7:0];
        else
            pix_c = ({20'd0, mag} >= THRESH_U) ? 8'hFF : 8'h00;
    end

    // stage 2: output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel_out <= 8'h00;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            pixel_out <= s1_valid ? pix_c : 8'h00;
            out_valid <= s1_valid;
            out_sof   <= s1_valid && s1_sof;
            out_eol   <= s1_valid && s1_eol;
        end
    end

endmodule

// File: tb/tb_sobel_edge.sv
// tb/tb_sobel_edge.sv - scoreboard bench for sobel_edge on a small frame
module tb_sobel_edge;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int TH = 600;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] gray_in = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] pixel_out, pixel_out2;
    logic       out_valid, out_sof, out_eol;
    logic       ov2, osof2, oeol2;

    sobel_edge #(.WIDTH(W), .HEIGHT(H), .THRESH(0)) dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .in_valid(in_valid), .in_sof(in_sof),
        .pixel_out(pixel_out), .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol)
    );

    sobel_edge #(.WIDTH(W), .HEIGHT(H), .THRESH(TH)) dut_bin (
        .clk(clk), .rst(rst), .gray_in(gray_in), .in_valid(in_valid), .in_sof(in_sof),
        .pixel_out(pixel_out2), .out_valid(ov2), .out_sof(osof2), .out_eol(oeol2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     pix;
        int     bin;
        bit     sof;
        bit     eol;
        longint cyc;
        int     cx;
        int     cy;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;
    int     cap [H][W];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // 0: flat 100, 1: vertical step at W/2, 2: impulse 20 at (3,2)
    function automatic int img(input int mode, input int px, input int py);
        case (mode)
            0: return 100;
            1: return (px < W / 2) ? 0 : 255;
            default: return (px == 3 && py == 2) ? 20 : 0;
        endcase
    endfunction

    function automatic int ref_mag(input int mode, input int cx, input int cy);
        int gx, gy;
        gx = img(mode, cx+1, cy-1) + 2*img(mode, cx+1, cy) + img(mode, cx+1, cy+1)
           - img(mode, cx-1, cy-1) - 2*img(mode, cx-1, cy) - img(mode, cx-1, cy+1);
        gy = img(mode, cx-1, cy+1) + 2*img(mode, cx, cy+1) + img(mode, cx+1, cy+1)
           - img(mode, cx-1, cy-1) - 2*img(mode, cx, cy-1) - img(mode, cx+1, cy-1);
        return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    endfunction

    task automatic send_px(input int mode, input int px, input int py, input bit sof, input bit gap);
        exp_t e;
        int   m;
        gray_in  = 8'(img(mode, px, py));
        in_valid = 1'b1;
        in_sof   = sof;
        if (px >= 2 && py >= 2) begin
            m     = ref_mag(mode, px-1, py-1);
            e.pix = (m > 255) ? 255 : m;
            e.bin = (m >= TH) ? 255 : 0;
            e.sof = (px == 2 && py == 2);
            e.eol = (px == W-1);
            e.cyc = cyc + 3;
            e.cx  = px - 1;
            e.cy  = py - 1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        gray_in  = 8'($urandom);
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int mode, input bit sof, input bit gap, input int rows);
        for (int fy = 0; fy < rows; fy++)
            for (int fx = 0; fx < W; fx++)
                send_px(mode, fx, fy, sof && fx == 0 && fy == 0, gap);
    endtask

    task automatic clear_cap();
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++)
                cap[i][j] = -1;
    endtask

    task automatic drain();
        repeat (5) @(posedge clk);
        #1;
    endtask

    // monitor: pop the scoreboard whenever the DUT presents an output
    always @(negedge clk) begin
        if (rst && (out_valid || ov2)) begin
            check("valid_pair", ov2, out_valid);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pixel", pixel_out, e.pix);
                    check("pixel_bin", pixel_out2, e.bin);
                    check("sof", out_sof, e.sof);
                    check("eol", out_eol, e.eol);
                    check("latency_cycle", cyc, e.cyc);
                    cap[e.cy][e.cx] = pixel_out;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, queue %0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        clear_cap();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pixel", pixel_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_sof", out_sof, 0);
        check("rst_eol", out_eol, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // flat frame
        send_frame(0, 1'b1, 1'b0, H);
        // step frame, then a second without in_sof (counter wrap)
        clear_cap();
        send_frame(1, 1'b1, 1'b0, H);
        send_frame(1, 1'b0, 1'b0, H);
        drain();
        check("step_c3", cap[2][3], 255);
        check("step_c4", cap[2][4], 255);
        check("step_c2", cap[2][2], 0);
        check("step_c5", cap[2][5], 0);

        // impulse
        clear_cap();
        send_frame(2, 1'b1, 1'b0, H);
        drain();
        check("imp_4_2", cap[2][4], 40);
        check("imp_3_3", cap[3][3], 40);
        check("imp_4_3", cap[3][4], 40);
        check("imp_3_2", cap[2][3], 0);

        // step with in_valid toggling every cycle
        send_frame(1, 1'b1, 1'b1, H);

        // mid-frame abort then a full flat frame
        send_frame(1, 1'b1, 1'b0, 4);
        send_frame(0, 1'b1, 1'b0, H);
        drain();

        // asynchronous reset mid-line while output is active
        send_frame(1, 1'b1, 1'b0, 3);
        for (int fx = 0; fx < 7; fx++)
            send_px(1, fx, 3, 1'b0, 1'b0);
        check("pre_rst_valid", out_valid, 1);
        #1 rst = 1'b0;
        #1;
        check("arst_pixel", pixel_out, 0);
        check("arst_valid", out_valid, 0);
        check("arst_sof", out_sof, 0);
        check("arst_eol", out_eol, 0);
        check("arst_valid_bin", ov2, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        send_frame(0, 1'b1, 1'b0, H);
        drain();

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_edge.md
# sobel_edge

Streaming 3x3 Sobel edge detector that sits directly downstream of the grayscale stage in the image pipeline. It consumes the raster-order 8-bit gray stream produced for each WIDTH x HEIGHT frame, buffers two previous lines, and computes |Gx|+|Gy| per interior pixel. It emits a raster-order edge-magnitude stream with per-frame and per-line markers for the display/capture stage.

## Interface
- WIDTH, 400: active pixels per line (≥3).
- HEIGHT, 266: lines per frame (≥3).
- THRESH, 0: 0 = output saturated magnitude; >0 = binary output, 255 if magnitude ≥ THRESH, else 0.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- gray_in  in  8  gray pixel (the parent slices [7:0] of the grayscale output).
- in_valid  in  1  gray_in is a valid pixel this cycle.
- in_sof  in  1  qualified by in_valid; the pixel is frame position (0,0).
- pixel_out  out  8  edge magnitude or binary edge.
- out_valid  out  1  pixel_out is valid.
- out_sof  out  1  with out_valid; first output of the frame, center (1,1).
- out_eol  out  1  with out_valid; last output of a line, center x = WIDTH-2.

## Operation
- No backpressure. Gaps (in_valid=0) stall all counters, buffers and the window. The pipeline still drains data already in flight.
- Position counters x (0..WIDTH-1) and y (0..HEIGHT-1) advance on each valid pixel.
  - x wraps to 0 at WIDTH-1 and increments y.
  - y wraps to 0 after HEIGHT-1 without needing in_sof.
- in_sof with in_valid forces the current pixel to (0,0), regardless of counter state.
- Two line buffers of WIDTH x 8 bits hold rows y-1 and y-2, addressed by x. Each valid pixel:
  - reads both buffers at x;
  - writes row y-1 data into the y-2 buffer;
  - writes gray_in into the y-1 buffer.
  - Buffers are not cleared on reset or sof; stale contents are never output (see suppression rule).
- A 3x3 window register shifts left each valid pixel. The new right column is {y-2 buffer, y-1 buffer, gray_in}.
  - The window is centered at (x-1, y-1) of the incoming pixel.
  - Name the taps prc: r = row 0..2 (top to bottom), c = col 0..2 (left to right).
- Gradients and magnitude:
  - Gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20), signed 11-bit.
  - Gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02), signed 11-bit.
  - mag = |Gx| + |Gy|, unsigned 12-bit, maximum 2040.
  - THRESH=0: pixel_out = min(mag, 255).
  - Otherwise: pixel_out = (mag ≥ THRESH) ? 255 : 0.
- Output suppression: an output is produced only for input pixels with x ≥ 2 and y ≥ 2, giving (WIDTH-2)·(HEIGHT-2) outputs per frame. Border centers produce no output.
- out_sof is set for input (2,2); out_eol is set for input x = WIDTH-1, y ≥ 2.
- Mid-frame in_sof aborts the current frame:
  - no further outputs from old rows;
  - in-flight stages still complete;
  - the next output is at input (2,2) of the new frame, with out_sof.

## Timing
- Stage 0, edge N (valid input): counters, buffer access and window shift. The qualification flags (valid, sof, eol) are captured.
- Stage 1, edge N+1: Gx and Gy registered.
- Stage 2, edge N+2: pixel_out, out_valid, out_sof and out_eol registered.
- Result: outputs are visible after edge N+2, a fixed 3-edge latency independent of input gaps.
- out_valid is high for exactly one cycle per qualifying input. Back-to-back inputs give back-to-back outputs.
- rst low forces these values immediately (asynchronous) and holds them until the first edge after release:
  - x, y, window, pipeline registers: 0;
  - pixel_out: 0x00;
  - out_valid, out_sof, out_eol: 0.
- Reset mid-frame discards all in-flight data. No out_valid occurs until a new input reaches (2,2).

## Test plan
- Flat frame, all pixels 100, continuous valid, in_sof on the first pixel:
  - exactly 398·264 = 105072 outputs, all 0x00;
  - out_sof only on the first; 264 out_eol pulses;
  - first out_valid 3 edges after input (2,2).
- Vertical step, pixel = 0 for x<200 and 255 for x≥200:
  - outputs at centers x=199 and x=200 are 255 (|Gx|=1020, saturated);
  - all other outputs are 0;
  - with THRESH=600: same 255/0 map.
- Impulse value 20 at (10,10), rest 0:
  - centers (11,10), (10,11), (11,11) each output 40;
  - center (10,10) outputs 0.
- Test 2 stimulus with in_valid toggling 1/0 every cycle: identical output values and count; each output exactly 3 edges after its qualifying input.
- in_sof asserted at input (0,100) mid-frame, followed by a full flat frame:
  - no outputs for new rows 0–1;
  - next output at new (2,2) with out_sof;
  - new frame output count 105072.
- rst asserted mid-line while out_valid=1:
  - pixel_out = 0 and all flags = 0 within the same cycle, without waiting for a clock edge;
  - after release and a new frame, behaviour matches the flat-frame test.
